cpu_boot_ctrl: RTL and testbench

CPU_BOOT_CTRL -- requirements
Module: cpu_boot_ctrl

---
 rtl/cpu_boot_ctrl.sv | 152 +++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_ctrl.sv
// Boot loader: buffers host code words in a small FIFO and streams them
// gaplessly into the CPU code BRAM, then releases the CPU into RUN.
module cpu_boot_ctrl #(
    parameter int CODE_WORDS = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic [2:1]  cpu_rst,
    output logic [15:0] cpu_par,
    output logic        boot_done,
    output logic        busy,
    output logic        err,
    output logic [11:0] words_loaded
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [11:0]   TOTAL = 12'(CODE_WORDS);

    typedef enum logic [2:0] {IDLE, FILL, LOAD, START, RUN} state_t;
    state_t state, state_nx;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic [11:0]   acc_cnt, acc_nx, loaded_nx;
    logic          push, pop, flush, clear, err_set;
    logic          boot_done_nx, ld_ready_nx, busy_nx;
    logic [2:1]    cpu_rst_nx;

    assign push = ld_valid & ld_ready;

    // Registered outputs are computed for the state being entered, so a pop
    // decided here lands on cpu_par in the same cycle that cpu_rst shows LOAD.
    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        flush        = 1'b0;
        clear        = 1'b0;
        err_set      = 1'b0;
        cpu_rst_nx   = 2'b00;
        boot_done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start && !halt) begin
                    state_nx = FILL;
                    clear    = 1'b1;
                end
            end
            FILL: begin
                if (halt) begin
                    state_nx = IDLE;
                    flush    = 1'b1;
                end else if (count == DEPTH || acc_cnt == TOTAL) begin
                    state_nx   = LOAD;
                    pop        = 1'b1;
                    cpu_rst_nx = 2'b01;
                end
            end
            LOAD: begin
                if (halt) begin
                    state_nx = IDLE;
                    flush    = 1'b1;
                end else if (words_loaded == TOTAL) begin
                    state_nx = START;
                end else if (count != '0) begin
                    pop        = 1'b1;
                    cpu_rst_nx = 2'b01;
                end else begin
                    // Underflow: abort instead of clocking a stale word in.
                    state_nx = IDLE;
                    flush    = 1'b1;
                    err_set  = 1'b1;
                end
            end
            START: begin
                if (halt) begin
                    state_nx = IDLE;
                    flush    = 1'b1;
                end else begin
                    state_nx     = RUN;
                    cpu_rst_nx   = 2'b10;
                    boot_done_nx = 1'b1;
                end
            end
            RUN: begin
                if (halt) begin
                    state_nx = IDLE;
                    flush    = 1'b1;
                end else begin
                    cpu_rst_nx = 2'b10;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        count_nx = count + CW'(push) - CW'(pop);
        if (flush || clear) count_nx = '0;
        acc_nx      = clear ? 12'd0 : acc_cnt + 12'(push);
        loaded_nx   = clear ? 12'd0 : words_loaded + 12'(pop);
        ld_ready_nx = (state_nx == FILL || state_nx == LOAD) &&
                      (count_nx < DEPTH) && (acc_nx < TOTAL);
        busy_nx     = (state_nx == FILL) || (state_nx == LOAD) || (state_nx == START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            acc_cnt      <= '0;
            ld_ready     <= 1'b0;
            cpu_rst      <= 2'b00;
            cpu_par      <= '0;
            boot_done    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            acc_cnt      <= acc_nx;
            words_loaded <= loaded_nx;
            ld_ready     <= ld_ready_nx;
            cpu_rst      <= cpu_rst_nx;
            boot_done    <= boot_done_nx;
            busy         <= busy_nx;
            err          <= clear ? 1'b0 : (err | err_set);
            if (pop) cpu_par <= mem[rd_ptr];
            if (flush || clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ld_data;
    end
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed self-checking bench for cpu_boot_ctrl with CODE_WORDS=32, FIFO_DEPTH=4.
module tb_cpu_boot_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = 16'h0;
    logic        ld_ready;
    logic [2:1]  cpu_rst;
    logic [15:0] cpu_par;
    logic        boot_done;
    logic        busy;
    logic        err;
    logic [11:0] words_loaded;

    cpu_boot_ctrl #(.CODE_WORDS(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_rst(cpu_rst), .cpu_par(cpu_par), .boot_done(boot_done),
        .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int passed = 0, failed = 0, total = 0;
    int cyc = 0, burst_base = 0;
    int host_idx = 0, host_limit = 0;
    bit host_on = 0, host_burst = 0;
    logic [15:0] exp_par = 16'h1000;
    int load_cycles = 0, done_pulses = 0;
    int first01 = -1, last01 = -1, done_cyc = -1, err_cyc = -1;
    int occ = 0, max_occ = 0, pushes_at_first = -1;
    bit full_viol = 0, neg_occ = 0, bad_11 = 0;
    int drop_at = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_host();
        ld_data  = 16'h1000 + 16'(host_idx);
        ld_valid = host_on && (host_idx < host_limit) &&
                   (!host_burst || ((cyc - burst_base) % 5) < 3);
    endtask

    // One clock: observe at the falling edge, then update host after the rising edge.
    task automatic tick();
        bit fire;
        @(negedge clk);
        if (cpu_rst === 2'b11) bad_11 = 1;
        if (cpu_rst === 2'b01) begin
            check("par_seq", 32'(cpu_par), 32'(exp_par));
            exp_par = exp_par + 16'd1;
            load_cycles++;
            if (first01 < 0) begin
                first01 = cyc;
                pushes_at_first = host_idx;
            end
            last01 = cyc;
            occ--;
        end
        if (boot_done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
        if (occ < 0) neg_occ = 1;
        if (occ >= 4 && ld_ready === 1'b1) full_viol = 1;
        fire = (ld_valid === 1'b1) && (ld_ready === 1'b1);
        @(posedge clk);
        #1;
        if (fire) begin
            host_idx++;
            occ++;
            if (occ > max_occ) max_occ = occ;
        end
        cyc++;
        drive_host();
    endtask

    task automatic new_boot(input int limit, input bit burst);
        exp_par = 16'h1000;
        host_idx = 0; occ = 0; max_occ = 0;
        load_cycles = 0; done_pulses = 0;
        first01 = -1; last01 = -1; done_cyc = -1; err_cyc = -1;
        pushes_at_first = -1; full_viol = 0; neg_occ = 0; drop_at = -1;
        host_limit = limit; host_burst = burst; host_on = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        burst_base = cyc;
        drive_host();
    endtask

    initial begin
        $display("[TB] reset checks");
        repeat (2) tick();
        check("rst_cpu_rst", 32'(cpu_rst), 32'h0);
        check("rst_cpu_par", 32'(cpu_par), 32'h0);
        check("rst_boot_done", 32'(boot_done), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_words", 32'(words_loaded), 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        check("idle_hold_busy", 32'(busy), 32'h0);
        check("idle_hold_ready", 32'(ld_ready), 32'h0);

        $display("[TB] gapless stream");
        new_boot(40, 0);
        check("fill_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 200; i++) begin
            if (done_pulses != 0) break;
            tick();
        end
        repeat (4) tick();
        check("gl_load_cycles", 32'(load_cycles), 32);
        check("gl_contiguous", 32'(last01 - first01 + 1), 32);
        check("gl_start_gap", 32'(done_cyc - last01), 2);
        check("gl_done_pulses", 32'(done_pulses), 1);
        check("gl_cpu_rst_run", 32'(cpu_rst), 32'h2);
        check("gl_words", 32'(words_loaded), 32);
        check("gl_err", 32'(err), 32'h0);
        check("gl_accepted", 32'(host_idx), 32);
        check("gl_first_push", 32'(pushes_at_first), 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("run_start_ignored_rst", 32'(cpu_rst), 32'h2);
        check("run_start_ignored_done", 32'(done_pulses), 1);

        $display("[TB] halt in RUN");
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_cpu_rst", 32'(cpu_rst), 32'h0);
        check("halt_busy", 32'(busy), 32'h0);
        check("halt_words_kept", 32'(words_loaded), 32);
        check("halt_err_kept", 32'(err), 32'h0);
        repeat (2) tick();
        check("halt_idle_stays", 32'(cpu_rst), 32'h0);
        new_boot(40, 0);
        for (int i = 0; i < 200; i++) begin
            if (done_pulses != 0) break;
            tick();
        end
        repeat (2) tick();
        check("reboot_load_cycles", 32'(load_cycles), 32);
        check("reboot_done", 32'(done_pulses), 1);
        check("reboot_words", 32'(words_loaded), 32);
        check("reboot_cpu_rst", 32'(cpu_rst), 32'h2);
        halt = 1'b1;
        tick();
        halt = 1'b0;

        $display("[TB] underflow");
        new_boot(10, 0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (host_idx == 10 && drop_at < 0) drop_at = cyc;
            if (drop_at >= 0 && cyc == drop_at + 20) begin
                host_limit = 40;
                drive_host();
            end
        end
        check("uf_err", 32'(err), 32'h1);
        check("uf_words", 32'(words_loaded), 10);
        check("uf_load_cycles", 32'(load_cycles), 10);
        check("uf_err_timing", 32'(err_cyc - last01), 1);
        check("uf_cpu_rst", 32'(cpu_rst), 32'h0);
        check("uf_busy", 32'(busy), 32'h0);
        check("uf_no_accept", 32'(host_idx), 10);
        check("uf_no_done", 32'(done_pulses), 0);

        $display("[TB] start+halt priority in FILL");
        new_boot(40, 0);
        check("pr_err_cleared", 32'(err), 32'h0);
        check("pr_words_cleared", 32'(words_loaded), 32'h0);
        tick();
        start = 1'b1;
        halt = 1'b1;
        tick();
        start = 1'b0;
        halt = 1'b0;
        check("pr_busy", 32'(busy), 32'h0);
        check("pr_ready", 32'(ld_ready), 32'h0);
        repeat (3) tick();
        check("pr_idle_stays", 32'(busy), 32'h0);
        check("pr_no_load", 32'(load_cycles), 0);

        $display("[TB] back-pressure bursts");
        new_boot(40, 1);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (load_cycles > 0 && busy === 1'b0) break;
        end
        check("bp_fill_waits", 32'(pushes_at_first), 4);
        check("bp_max_occ", 32'(max_occ), 4);
        check("bp_ready_when_full", 32'(full_viol), 32'h0);
        check("bp_no_underpop", 32'(neg_occ), 32'h0);
        check("bp_words_match", 32'(words_loaded), 32'(load_cycles));
        check("bp_err_consistent", 32'(err), 32'(load_cycles != 32));
        halt = 1'b1;
        tick();
        halt = 1'b0;

        $display("[TB] async reset mid-LOAD");
        new_boot(40, 0);
        for (int i = 0; i < 50; i++) begin
            if (load_cycles >= 5) break;
            tick();
        end
        check("ar_in_load", 32'(cpu_rst), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("ar_cpu_rst", 32'(cpu_rst), 32'h0);
        check("ar_cpu_par", 32'(cpu_par), 32'h0);
        check("ar_boot_done", 32'(boot_done), 32'h0);
        check("ar_ready", 32'(ld_ready), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_err", 32'(err), 32'h0);
        check("ar_words", 32'(words_loaded), 32'h0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("ar_idle_after", 32'(busy), 32'h0);
        check("ar_no_done", 32'(done_pulses), 0);
        check("never_cpu_rst_11", 32'(bad_11), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
